c66x_enable_ctrl: RTL

C66X_ENABLE_CTRL -- requirements
Module: c66x_enable_ctrl

---
 rtl/c66x_enable_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/c66x_enable_ctrl.sv
// Power-sequencer enable controller: POR hold-off, host request tracking, retry/backoff and fault latch.
// Optional feature: define C66X_ENABLE_CTRL_AUTORETRY_EN for retry with backoff; otherwise any failure latches FAULT.
module c66x_enable_ctrl #(
   parameter int TICK_DIV      = 8192,
   parameter int POR_TICKS     = 5,
   parameter int BACKOFF_TICKS = 16,
   parameter int STABLE_TICKS  = 64,
   parameter int MAX_RETRIES   = 3
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       host_on_req,
   input  logic       fault_clear,
   input  logic [3:0] seq_state,
   output logic       enable,
   output logic       fault,
   output logic [1:0] retry_count,
   output logic [2:0] ctrl_state
);

   typedef enum logic [2:0] {
      ST_POR_WAIT = 3'b000,
      ST_IDLE     = 3'b001,
      ST_REQ_ON   = 3'b010,
      ST_RUNNING  = 3'b011,
      ST_BACKOFF  = 3'b100,
      ST_FAULT    = 3'b101
   } state_t;

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [7:0] POR_T     = 8'(POR_TICKS);
   localparam logic [7:0] BACKOFF_T = 8'(BACKOFF_TICKS);
   localparam logic [7:0] STABLE_T  = 8'(STABLE_TICKS);
   localparam logic [1:0] MAX_RC    = 2'(MAX_RETRIES);
   localparam logic [3:0] SEQ_ON    = 4'b1001;
   localparam logic [3:0] SEQ_BAD   = 4'b1010;

`ifdef C66X_ENABLE_CTRL_AUTORETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   state_t           state;
   state_t           state_next;
   logic [1:0]       rc_next;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [7:0]       tick_cnt;
   logic             host_meta;
   logic             host_sync;
   logic [3:0]       seq_q;
   logic             seq_fail;
   logic             en_next;

   // TICK_DIV is a power of two, so the divider simply wraps.
   assign tick       = &div_cnt;
   assign seq_fail   = (seq_q >= SEQ_BAD);
   assign ctrl_state = state;
   assign en_next    = (state_next == ST_REQ_ON) || (state_next == ST_RUNNING);

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         div_cnt   <= '0;
         host_meta <= 1'b0;
         host_sync <= 1'b0;
         seq_q     <= 4'b0000;
      end else begin
         div_cnt   <= div_cnt + DIV_W'(1);
         host_meta <= host_on_req;
         host_sync <= host_meta;
         seq_q     <= seq_state;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tick_cnt <= 8'd0;
      end else if (state_next != state) begin
         tick_cnt <= 8'd0;
      end else if (tick && (tick_cnt != 8'hFF)) begin
         tick_cnt <= tick_cnt + 8'd1;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state       <= ST_POR_WAIT;
         retry_count <= 2'd0;
         enable      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state       <= state_next;
         retry_count <= rc_next;
         enable      <= en_next;
         fault       <= (state_next == ST_FAULT);
      end
   end

   always_comb begin
      state_next = state;
      rc_next    = retry_count;
      if (fault_clear) begin
         rc_next = 2'd0;
      end
      case (state)
         ST_POR_WAIT: begin
            if (tick_cnt >= POR_T) begin
               state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (host_sync) begin
               state_next = ST_REQ_ON;
            end
         end
         ST_REQ_ON, ST_RUNNING: begin
            // Host withdrawal wins over a coincident sequencer failure.
            if (!host_sync) begin
               state_next = ST_IDLE;
            end else if (seq_fail) begin
               if (RETRY_EN && (retry_count < MAX_RC)) begin
                  state_next = ST_BACKOFF;
                  rc_next    = retry_count + 2'd1;
               end else begin
                  state_next = ST_FAULT;
               end
            end else if ((state == ST_REQ_ON) && (seq_q == SEQ_ON)) begin
               state_next = ST_RUNNING;
            end else if ((state == ST_RUNNING) && (tick_cnt == STABLE_T)) begin
               rc_next = 2'd0;
            end
         end
         ST_BACKOFF: begin
            if (tick_cnt >= BACKOFF_T) begin
               state_next = host_sync ? ST_REQ_ON : ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (fault_clear) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule
